// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and baud helper for the FIFO UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter emitting a one-cycle bit_done pulse
// Counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary; held at 0 while cleared.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_Clear,
    output logic o_Bit_Done
);

    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    assign o_Bit_Done = !i_Clear && (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            count <= '0;
        end else if (i_Clear || o_Bit_Done) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that pops bytes from the TX FIFO read side
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_Enable,
    input  logic       i_Fifo_Empty,
    input  logic [7:0] i_Fifo_Data,
    output logic       o_Fifo_Read_EN,
    output logic       o_TX,
    output logic       o_Busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
        $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
    end

    uart_state_t state, state_next;
    logic [7:0]  shifter, shifter_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic        par_bit, par_next;
    logic        tx_next;
    logic        bit_done;
    logic        baud_clear;

    // Bit timing only runs once the byte is loaded, so START always begins at count 0.
    assign baud_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .i_Clear   (baud_clear),
        .o_Bit_Done(bit_done)
    );

    always_comb begin
        state_next   = state;
        shifter_next = shifter;
        bit_idx_next = bit_idx;
        par_next     = par_bit;
        tx_next      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (i_Enable && !i_Fifo_Empty) state_next = ST_POP;
            end
            ST_POP: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shifter_next = i_Fifo_Data;
                par_next     = (PARITY == PARITY_ODD) ? ~^i_Fifo_Data : ^i_Fifo_Data;
                bit_idx_next = '0;
                state_next   = ST_START;
            end
            ST_START: begin
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shifter_next = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) state_next = ST_STOP;
            end
            ST_STOP: begin
                // bit_idx is reused to count stop bits.
                if (bit_done) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        bit_idx_next = '0;
                        state_next   = ST_IDLE;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The line level is registered from the upcoming state so o_TX comes straight off a flop.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shifter_next[0];
            ST_PARITY: tx_next = par_next;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state          <= ST_IDLE;
            shifter        <= '0;
            bit_idx        <= '0;
            par_bit        <= 1'b0;
            o_TX           <= 1'b1;
            o_Fifo_Read_EN <= 1'b0;
            o_Busy         <= 1'b0;
        end else begin
            state          <= state_next;
            shifter        <= shifter_next;
            bit_idx        <= bit_idx_next;
            par_bit        <= par_next;
            o_TX           <= tx_next;
            o_Fifo_Read_EN <= (state_next == ST_POP);
            o_Busy         <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx (three parity/stop configurations)
module tb_fifo_uart_tx;

    localparam int CPB = 10;

    function automatic int par_of(input int i);
        return i;
    endfunction
    function automatic int stp_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      en = 3'b000;
    logic [2:0]      empty;
    logic [2:0][7:0] fdata = '0;
    logic [2:0]      rd, tx, busy;

    logic [7:0] fmem [3][64];
    int wp [3] = '{0, 0, 0};
    int rp [3] = '{0, 0, 0};
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int strobes [3] = '{0, 0, 0};

    int          mpop  [3] = '{-100, -100, -100};
    int          mfst  [3] = '{-100, -100, -100};
    int          mfend [3] = '{-100, -100, -100};
    int          mrp   [3] = '{0, 0, 0};
    logic [12:0] mbits [3];

    initial forever #5 clk = ~clk;

    fifo_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(par_of(0)), .STOP_BITS(stp_of(0))) u_dut0 (
        .i_CLK(clk), .i_RESET(rst), .i_Enable(en[0]), .i_Fifo_Empty(empty[0]), .i_Fifo_Data(fdata[0]),
        .o_Fifo_Read_EN(rd[0]), .o_TX(tx[0]), .o_Busy(busy[0]));
    fifo_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(par_of(1)), .STOP_BITS(stp_of(1))) u_dut1 (
        .i_CLK(clk), .i_RESET(rst), .i_Enable(en[1]), .i_Fifo_Empty(empty[1]), .i_Fifo_Data(fdata[1]),
        .o_Fifo_Read_EN(rd[1]), .o_TX(tx[1]), .o_Busy(busy[1]));
    fifo_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(par_of(2)), .STOP_BITS(stp_of(2))) u_dut2 (
        .i_CLK(clk), .i_RESET(rst), .i_Enable(en[2]), .i_Fifo_Empty(empty[2]), .i_Fifo_Data(fdata[2]),
        .o_Fifo_Read_EN(rd[2]), .o_TX(tx[2]), .o_Busy(busy[2]));

    // FIFO read side: registered data the cycle after a strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) begin
                fdata[i] <= fmem[i][rp[i] % 64];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int i = 0; i < 3; i++) empty[i] = (wp[i] == rp[i]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Frame-level reference: once idle with enable and data, pop next cycle,
    // start bit two cycles later, each frame bit held CPB cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin : model
            logic [2:0] e;
            logic [7:0] d;
            int k, n;
            k = cyc;
            strobes[i] += int'(rd[i]);
            if (rst) begin
                e = 3'b100;
                mpop[i] = -100; mfst[i] = -100; mfend[i] = -100;
            end else begin
                e[2] = (k >= mfst[i] && k < mfend[i]) ? mbits[i][(k - mfst[i]) / CPB] : 1'b1;
                e[1] = (k == mpop[i]);
                e[0] = (k >= mpop[i] && k < mfend[i]);
            end
            chk($sformatf("cycle_inst%0d{tx,rd,busy}", i), {29'd0, tx[i], rd[i], busy[i]}, {29'd0, e});
            if (!rst && k >= mfend[i] && en[i] && wp[i] != mrp[i]) begin
                d = fmem[i][mrp[i] % 64];
                mrp[i]++;
                mbits[i] = '0;
                n = 1;
                for (int b = 0; b < 8; b++) begin mbits[i][n] = d[b]; n++; end
                if (par_of(i) != 0) begin
                    mbits[i][n] = (par_of(i) == 1) ? ^d : ~^d;
                    n++;
                end
                for (int s = 0; s < stp_of(i); s++) begin mbits[i][n] = 1'b1; n++; end
                mpop[i]  = k + 1;
                mfst[i]  = k + 3;
                mfend[i] = k + 3 + n * CPB;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][wp[i] % 64] = b;
        wp[i]++;
    endtask

    task automatic wait_start(input int i, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx[i] == 1'b0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout inst%0d: no start bit in 400 clks, required one", i);
        end
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  data;
        int          nbits;
        logic [12:0] levels;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int t;
        bit ok;
        logic [12:0] got;
        tick();
        push(v.inst, v.data);
        wait_start(v.inst, t, ok);
        if (ok) begin
            got = '0;
            repeat (CPB / 2) @(negedge clk);
            for (int b = 0; b < v.nbits; b++) begin
                got[b] = tx[v.inst];
                if (b != v.nbits - 1) repeat (CPB) @(negedge clk);
            end
            chk($sformatf("frame_bits_inst%0d_%02h", v.inst, v.data), {19'd0, got}, {19'd0, v.levels});
            repeat (CPB / 2 - 1) @(negedge clk);
            chk("busy_last_stop_clk", {31'd0, busy[v.inst]}, 32'd1);
            @(negedge clk);
            chk("busy_after_stop", {31'd0, busy[v.inst]}, 32'd0);
        end
    endtask

    vec_t vecs [7];

    initial begin
        int t1, t2, s0;
        bit ok1, ok2;

        vecs[0] = '{0, 8'h55, 10, 13'b1_01010101_0};
        vecs[1] = '{0, 8'hA5, 10, 13'b1_10100101_0};
        vecs[2] = '{1, 8'h07, 12, 13'b11_1_00000111_0};
        vecs[3] = '{2, 8'h07, 11, 13'b1_0_00000111_0};
        vecs[4] = '{1, 8'h00, 12, 13'b11_0_00000000_0};
        vecs[5] = '{2, 8'hFF, 11, 13'b1_1_11111111_0};
        vecs[6] = '{1, 8'h80, 12, 13'b11_1_10000000_0};

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_tx", {31'd0, tx[i]}, 32'd1);
            chk("reset_rd", {31'd0, rd[i]}, 32'd0);
            chk("reset_busy", {31'd0, busy[i]}, 32'd0);
        end
        tick();
        rst = 1'b0;

        // Enabled with an empty FIFO: nothing happens
        tick();
        en = 3'b111;
        repeat (500) tick();
        chk("empty_no_strobe", strobes[0] + strobes[1] + strobes[2], 0);
        chk("empty_tx_idle", {29'd0, tx}, 32'd7);

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // Back-to-back frames: exactly 3 idle-high cycles between them
        tick();
        s0 = strobes[0];
        push(0, 8'hA5);
        push(0, 8'h3C);
        wait_start(0, t1, ok1);
        repeat (100) @(negedge clk);
        wait_start(0, t2, ok2);
        if (ok1 && ok2) chk("b2b_start_spacing", t2 - t1, 103);
        repeat (110) @(negedge clk);
        chk("b2b_strobes", strobes[0] - s0, 2);

        // Reset during data bit 3 of 0xF0
        tick();
        push(0, 8'hF0);
        wait_start(0, t1, ok1);
        if (ok1) begin
            repeat (43) tick();
            chk("pre_reset_bit3", {31'd0, tx[0]}, 32'd0);
            rst = 1'b1;
            #1;
            chk("reset_mid_tx", {31'd0, tx[0]}, 32'd1);
            chk("reset_mid_busy", {31'd0, busy[0]}, 32'd0);
            repeat (3) tick();
            rst = 1'b0;
            s0 = strobes[0];
            repeat (200) tick();
            chk("post_reset_no_strobe", strobes[0] - s0, 0);
            chk("post_reset_tx", {31'd0, tx[0]}, 32'd1);
        end

        // Enable dropped mid-frame with a second byte queued
        tick();
        s0 = strobes[0];
        push(0, 8'h81);
        push(0, 8'h42);
        wait_start(0, t1, ok1);
        if (ok1) begin
            repeat (33) tick();
            en[0] = 1'b0;
            repeat (120) tick();
            chk("en_drop_one_strobe", strobes[0] - s0, 1);
            chk("en_drop_idle", {31'd0, busy[0]}, 32'd0);
            chk("en_drop_queued", wp[0] - rp[0], 1);
            en[0] = 1'b1;
            wait_start(0, t2, ok2);
            repeat (110) @(negedge clk);
            chk("en_return_strobes", strobes[0] - s0, 2);
        end

        // Randomised traffic checked cycle by cycle by the reference model
        for (int n = 0; n < 4000; n++) begin : rnd
            int i;
            tick();
            if ($urandom_range(0, 59) == 0) begin
                i = int'($urandom_range(0, 2));
                if (wp[i] - rp[i] < 40) push(i, 8'($urandom));
            end
            if ($urandom_range(0, 149) == 0) begin
                i = int'($urandom_range(0, 2));
                en[i] = ~en[i];
            end
        end
        en = 3'b111;
        begin : drain
            bit done;
            done = 1'b0;
            for (int n = 0; n < 20000 && !done; n++) begin
                tick();
                done = (wp[0] == rp[0]) && (wp[1] == rp[1]) && (wp[2] == rp[2]) && (busy == 3'b000);
            end
            chk("drain_complete", {31'd0, done}, 32'd1);
        end
        repeat (5) tick();
        for (int i = 0; i < 3; i++) chk($sformatf("total_strobes_inst%0d", i), strobes[i], wp[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
